mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the datapath, directly downstream of the execution stage. It takes the execution result as the effective address and rs2 as store data, and runs one load or store per request on a simple request/acknowledge data bus. Loads are returned with lane extraction and sign/zero extension. It stalls the pipeline until the bus acknowledges, and flags misaligned accesses without touching the bus.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-low.
- i_en  in  1  memory operation present in the EX/MEM pipeline register.
- i_we  in  1  1 = store, 0 = load.
- i_f3  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Reserved codes (011, 110, 111) are treated as W.
- i_addr  in  XLEN  effective address (the execution-stage result).
- i_wdata  in  XLEN  store data (rs2).
- o_rdata  out  XLEN  formatted load result.
- o_stall  out  1  holds the pipeline.
- o_misaligned  out  1  misaligned-access indication.
- o_bus_en  out  1  bus request.
- o_bus_we  out  1  bus write.
- o_bus_addr  out  XLEN  word-aligned address, with addr[1:0] = 00.
- o_bus_wdata  out  XLEN  lane-replicated store data.
- o_bus_be  out  4  byte enables.
- i_bus_rdata  in  XLEN  bus read data; valid only with i_bus_ack.
- i_bus_ack  in  1  bus completion.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- Misalignment rule: a misaligned access is H/HU with addr[0]=1, or W with addr[1:0]≠00.
- IDLE:
  - If i_en is high and the access is aligned: register we, f3, addr[1:0], the bus address, wdata and be; go to BUS.
  - If i_en is high and the access is misaligned: o_misaligned=1 combinationally, o_stall=0, no bus request; stay in IDLE.
- BUS:
  - o_bus_en=1 with all bus outputs stable until i_bus_ack is sampled high.
  - On ack: for a load, capture the formatted i_bus_rdata into o_rdata. Go to DONE.
- DONE: o_stall=0 for exactly one cycle; go to IDLE unconditionally. The pipeline advances in this cycle, so the same operation is not re-issued.
- o_stall = i_en & (state==IDLE & aligned | state==BUS). o_stall is 0 in DONE.
- Store formatting:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << (2·addr[1]); wdata = {2{wdata[15:0]}}.
  - SW: be = 1111; wdata unchanged.
- Load formatting:
  - Select byte lane addr[1:0] or half lane addr[1] from i_bus_rdata.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- o_rdata holds its value until the next load completes; stores never change it.
- During stores, i_bus_rdata is ignored.
- i_en falling while in BUS does not abort the transaction. It completes normally; i_en is ignored outside IDLE.
- i_bus_ack is ignored in IDLE and DONE, including a stale ack after reset.

## Timing
- Reset values: state IDLE; o_rdata=0; o_bus_en=0, o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_bus_be=0. o_stall and o_misaligned are 0 while i_en=0.
- A reset asserted mid-transaction drops o_bus_en at the next edge and returns the FSM to IDLE.
- Latency with zero wait states:
  - Cycle 0: i_en, IDLE, stall=1.
  - Cycle 1: BUS, o_bus_en=1, ack=1.
  - Cycle 2: DONE, stall=0, o_rdata valid.
  - Each extra cycle without ack adds one stall cycle.
- The bus slave must not assert ack in the same cycle as the request's first appearance unless it has already sampled it. Ack is sampled on the rising edge at which o_bus_en=1.
- Back-to-back operations: the earliest next request is issued on the cycle after DONE, giving a minimum of 3 cycles per access.
- o_misaligned is combinational and valid in the same cycle as i_en; it is not registered.

## Test plan
- **LW, zero wait.** i_addr=0x100, bus returns 0xDEADBEEF with immediate ack.
  - o_bus_addr=0x100, be=1111, stall for cycles 0–1.
  - Cycle 2: o_rdata=0xDEADBEEF, stall=0.
- **LB/LBU, lane 3.** i_addr=0x103, rdata=0x80112233.
  - LB → o_rdata=0xFFFFFF80.
  - LBU → o_rdata=0x00000080.
  - o_bus_addr=0x100.
- **SH, upper half.** addr=0x202, wdata=0x0000A5C3 → o_bus_we=1, be=1100, o_bus_wdata=0xA5C3A5C3, o_bus_addr=0x200; o_rdata unchanged.
- **Wait states.** LW with ack delayed 4 cycles → o_bus_en and bus fields held stable for 5 BUS cycles, 6 stall cycles total, then one DONE cycle.
- **Misaligned.** LW at 0x101 and SH at 0x301 → o_misaligned=1 and o_stall=0 in the same cycle; o_bus_en stays 0.
- **Reset mid-BUS.** i_rst=0 while waiting for ack → next cycle o_bus_en=0, o_rdata=0. A later ack in IDLE causes no state change.

Source files
------------

// File: rtl/mem_stage_if.sv
// Pipeline-side and data-bus-side signals of the memory-access stage.
// Latency: none (signal bundle only).
// Backpressure: o_stall toward the pipeline, i_bus_ack from the bus slave.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  // Pipeline side (EX/MEM register)
  logic            i_en;
  logic            i_we;
  logic [2:0]      i_f3;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_wdata;
  logic [XLEN-1:0] o_rdata;
  logic            o_stall;
  logic            o_misaligned;
  // Data bus side
  logic            o_bus_en;
  logic            o_bus_we;
  logic [XLEN-1:0] o_bus_addr;
  logic [XLEN-1:0] o_bus_wdata;
  logic [3:0]      o_bus_be;
  logic [XLEN-1:0] i_bus_rdata;
  logic            i_bus_ack;

  // The memory stage itself
  modport slave (
    input  i_en, i_we, i_f3, i_addr, i_wdata, i_bus_rdata, i_bus_ack,
    output o_rdata, o_stall, o_misaligned,
           o_bus_en, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be
  );

  // The environment: pipeline plus bus slave
  modport master (
    output i_en, i_we, i_f3, i_addr, i_wdata, i_bus_rdata, i_bus_ack,
    input  o_rdata, o_stall, o_misaligned,
           o_bus_en, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one load/store per request on a req/ack bus, with load lane extraction/extension.
// Latency: 3 cycles per aligned access with zero wait states (IDLE, BUS, DONE); misaligned flagged in 0 cycles.
// Backpressure: o_stall holds the pipeline until i_bus_ack is sampled; bus outputs held stable while waiting.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mem_stage_if.slave  mif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  // Access size decode: f3[1] set covers W and all reserved codes.
  logic is_word, is_half, misaligned_acc, in_idle;
  assign is_word        = mif.i_f3[1];
  assign is_half        = ~mif.i_f3[1] & mif.i_f3[0];
  assign misaligned_acc = (is_half & mif.i_addr[0]) | (is_word & (mif.i_addr[1:0] != 2'b00));
  assign in_idle        = (state_q == IDLE);

  // Store formatting: byte enables and lane-replicated data
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mif.i_wdata;
    if (!is_word) begin
      if (is_half) begin
        st_be    = 4'b0011 << {mif.i_addr[1], 1'b0};
        st_wdata = {2{mif.i_wdata[15:0]}};
      end else begin
        st_be    = 4'b0001 << mif.i_addr[1:0];
        st_wdata = {4{mif.i_wdata[7:0]}};
      end
    end
  end

  // Load formatting: shift the addressed lane down, then sign/zero extend.
  // Halfword accesses are aligned, so the byte shift also selects the half lane.
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_fmt;
  logic            ld_signed;
  assign ld_shift  = mif.i_bus_rdata >> {lane_q, 3'b000};
  assign ld_signed = ~f3_q[2];
  always_comb begin
    ld_fmt = mif.i_bus_rdata;
    if (!f3_q[1]) begin
      if (f3_q[0]) begin
        ld_fmt = {{(XLEN-16){ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      end else begin
        ld_fmt = {{(XLEN-8){ld_signed & ld_shift[7]}}, ld_shift[7:0]};
      end
    end
  end

  // Next-state and captured-field logic for the IDLE -> BUS -> DONE sequence
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mif.i_en && !misaligned_acc) begin
          we_d    = mif.i_we;
          f3_d    = mif.i_f3;
          lane_d  = mif.i_addr[1:0];
          addr_d  = {mif.i_addr[XLEN-1:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          state_d = BUS;
        end
      end
      BUS: begin
        if (mif.i_bus_ack) begin
          if (!we_q) begin
            rdata_d = ld_fmt;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured fields, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  assign mif.o_bus_en     = (state_q == BUS);
  assign mif.o_bus_we     = we_q;
  assign mif.o_bus_addr   = addr_q;
  assign mif.o_bus_wdata  = wdata_q;
  assign mif.o_bus_be     = be_q;
  assign mif.o_rdata      = rdata_q;
  assign mif.o_misaligned = mif.i_en & in_idle & misaligned_acc;
  assign mif.o_stall      = mif.i_en & ((in_idle & ~misaligned_acc) | (state_q == BUS));

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  mem_stage_if #(.XLEN(32)) mif ();

  mem_stage #(.XLEN(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .mif   (mif)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present an operation on the pipeline side
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    mif.i_en    = 1'b1;
    mif.i_we    = we;
    mif.i_f3    = f3;
    mif.i_addr  = addr;
    mif.i_wdata = wdata;
    #1;
  endtask

  task automatic test_reset();
    mif.i_en = 1'b0; mif.i_we = 1'b0; mif.i_f3 = 3'b010; mif.i_addr = '0; mif.i_wdata = '0;
    mif.i_bus_rdata = 32'hCAFEF00D; mif.i_bus_ack = 1'b1;
    i_rst = 1'b0;
    tick(); tick();
    tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL rst_bus_en got %h exp 0", mif.o_bus_en); end
    tests_run++; if (mif.o_bus_we !== 1'b0) begin tests_failed++; $display("FAIL rst_bus_we got %h exp 0", mif.o_bus_we); end
    tests_run++; if (mif.o_bus_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_bus_addr got %h exp 0", mif.o_bus_addr); end
    tests_run++; if (mif.o_bus_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_bus_wdata got %h exp 0", mif.o_bus_wdata); end
    tests_run++; if (mif.o_bus_be !== 4'h0) begin tests_failed++; $display("FAIL rst_bus_be got %h exp 0", mif.o_bus_be); end
    tests_run++; if (mif.o_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata got %h exp 0", mif.o_rdata); end
    tests_run++; if (mif.o_stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall got %h exp 0", mif.o_stall); end
    tests_run++; if (mif.o_misaligned !== 1'b0) begin tests_failed++; $display("FAIL rst_misaligned got %h exp 0", mif.o_misaligned); end
    // Stale ack after reset release must not move the FSM
    i_rst = 1'b1;
    tick(); tick();
    tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL stale_ack_bus_en got %h exp 0", mif.o_bus_en); end
    tests_run++; if (mif.o_rdata !== 32'h0) begin tests_failed++; $display("FAIL stale_ack_rdata got %h exp 0", mif.o_rdata); end
    mif.i_bus_ack = 1'b0;
  endtask

  task automatic test_lw_zero_wait();
    tick();
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    // Cycle 0: IDLE with request
    tests_run++; if (mif.o_stall !== 1'b1) begin tests_failed++; $display("FAIL lw_c0_stall got %h exp 1", mif.o_stall); end
    tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL lw_c0_bus_en got %h exp 0", mif.o_bus_en); end
    tick();
    // Cycle 1: BUS, slave acks immediately
    mif.i_bus_rdata = 32'hDEADBEEF; mif.i_bus_ack = 1'b1; #1;
    tests_run++; if (mif.o_bus_en !== 1'b1) begin tests_failed++; $display("FAIL lw_c1_bus_en got %h exp 1", mif.o_bus_en); end
    tests_run++; if (mif.o_bus_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL lw_c1_addr got %h exp 00000100", mif.o_bus_addr); end
    tests_run++; if (mif.o_bus_be !== 4'b1111) begin tests_failed++; $display("FAIL lw_c1_be got %b exp 1111", mif.o_bus_be); end
    tests_run++; if (mif.o_bus_we !== 1'b0) begin tests_failed++; $display("FAIL lw_c1_we got %h exp 0", mif.o_bus_we); end
    tests_run++; if (mif.o_stall !== 1'b1) begin tests_failed++; $display("FAIL lw_c1_stall got %h exp 1", mif.o_stall); end
    tick();
    // Cycle 2: DONE
    mif.i_bus_ack = 1'b0; mif.i_bus_rdata = 32'h0; #1;
    tests_run++; if (mif.o_stall !== 1'b0) begin tests_failed++; $display("FAIL lw_c2_stall got %h exp 0", mif.o_stall); end
    tests_run++; if (mif.o_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_c2_rdata got %h exp deadbeef", mif.o_rdata); end
    tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL lw_c2_bus_en got %h exp 0", mif.o_bus_en); end
    mif.i_en = 1'b0;
  endtask

  // LB then LBU back to back at lane 3
  task automatic test_back_to_back();
    logic [2:0]  f3s [2];
    logic [31:0] exp [2];
    f3s[0] = 3'b000; exp[0] = 32'hFFFFFF80;
    f3s[1] = 3'b100; exp[1] = 32'h00000080;
    tick();
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, f3s[k], 32'h0000_0103, 32'h0);
      tests_run++; if (mif.o_stall !== 1'b1) begin tests_failed++; $display("FAIL b2b%0d_idle_stall got %h exp 1", k, mif.o_stall); end
      tick();
      mif.i_bus_rdata = 32'h80112233; mif.i_bus_ack = 1'b1; #1;
      tests_run++; if (mif.o_bus_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL b2b%0d_addr got %h exp 00000100", k, mif.o_bus_addr); end
      tick();
      mif.i_bus_ack = 1'b0; #1;
      tests_run++; if (mif.o_rdata !== exp[k]) begin tests_failed++; $display("FAIL b2b%0d_rdata got %h exp %h", k, mif.o_rdata, exp[k]); end
      tests_run++; if (mif.o_stall !== 1'b0) begin tests_failed++; $display("FAIL b2b%0d_done_stall got %h exp 0", k, mif.o_stall); end
      tick();
    end
    mif.i_en = 1'b0;
  endtask

  // Halfword loads with sign/zero extension, upper lane
  task automatic test_lh();
    logic [2:0]  f3s [2];
    logic [31:0] exp [2];
    f3s[0] = 3'b001; exp[0] = 32'hFFFF8001;
    f3s[1] = 3'b101; exp[1] = 32'h00008001;
    for (int k = 0; k < 2; k++) begin
      tick();
      issue(1'b0, f3s[k], 32'h0000_0402, 32'h0);
      tick();
      mif.i_bus_rdata = 32'h80017F00; mif.i_bus_ack = 1'b1;
      tick();
      mif.i_bus_ack = 1'b0; mif.i_en = 1'b0; #1;
      tests_run++; if (mif.o_rdata !== exp[k]) begin tests_failed++; $display("FAIL lh%0d_rdata got %h exp %h", k, mif.o_rdata, exp[k]); end
    end
  endtask

  task automatic test_stores();
    // SH upper half
    tick();
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000A5C3);
    tick();
    mif.i_bus_rdata = 32'h11111111; mif.i_bus_ack = 1'b1; #1;
    tests_run++; if (mif.o_bus_we !== 1'b1) begin tests_failed++; $display("FAIL sh_we got %h exp 1", mif.o_bus_we); end
    tests_run++; if (mif.o_bus_be !== 4'b1100) begin tests_failed++; $display("FAIL sh_be got %b exp 1100", mif.o_bus_be); end
    tests_run++; if (mif.o_bus_wdata !== 32'hA5C3A5C3) begin tests_failed++; $display("FAIL sh_wdata got %h exp a5c3a5c3", mif.o_bus_wdata); end
    tests_run++; if (mif.o_bus_addr !== 32'h0000_0200) begin tests_failed++; $display("FAIL sh_addr got %h exp 00000200", mif.o_bus_addr); end
    tick();
    mif.i_bus_ack = 1'b0; mif.i_en = 1'b0; #1;
    tests_run++; if (mif.o_rdata !== 32'h00008001) begin tests_failed++; $display("FAIL sh_rdata_kept got %h exp 00008001", mif.o_rdata); end
    // SB lane 1
    tick();
    issue(1'b1, 3'b000, 32'h0000_0301, 32'h1234567E);
    tick();
    mif.i_bus_ack = 1'b1; #1;
    tests_run++; if (mif.o_bus_be !== 4'b0010) begin tests_failed++; $display("FAIL sb_be got %b exp 0010", mif.o_bus_be); end
    tests_run++; if (mif.o_bus_wdata !== 32'h7E7E7E7E) begin tests_failed++; $display("FAIL sb_wdata got %h exp 7e7e7e7e", mif.o_bus_wdata); end
    tick();
    mif.i_bus_ack = 1'b0; mif.i_en = 1'b0;
  endtask

  task automatic test_wait_states();
    int stall_cnt;
    stall_cnt = 0;
    tick();
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    if (mif.o_stall === 1'b1) stall_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      mif.i_bus_rdata = 32'h12345678; mif.i_bus_ack = (i == 4); #1;
      if (mif.o_stall === 1'b1) stall_cnt++;
      tests_run++; if (mif.o_bus_en !== 1'b1 || mif.o_bus_addr !== 32'h0000_0500 || mif.o_bus_be !== 4'b1111) begin
        tests_failed++; $display("FAIL wait_bus_c%0d got en=%h addr=%h be=%b exp en=1 addr=00000500 be=1111", i, mif.o_bus_en, mif.o_bus_addr, mif.o_bus_be);
      end
    end
    tick();
    mif.i_bus_ack = 1'b0; #1;
    tests_run++; if (mif.o_stall !== 1'b0) begin tests_failed++; $display("FAIL wait_done_stall got %h exp 0", mif.o_stall); end
    tests_run++; if (stall_cnt !== 6) begin tests_failed++; $display("FAIL wait_stall_cycles got %0d exp 6", stall_cnt); end
    tests_run++; if (mif.o_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL wait_rdata got %h exp 12345678", mif.o_rdata); end
    mif.i_en = 1'b0;
  endtask

  task automatic test_misaligned();
    logic        wes   [2];
    logic [2:0]  f3s   [2];
    logic [31:0] addrs [2];
    wes[0] = 1'b0; f3s[0] = 3'b010; addrs[0] = 32'h0000_0101;
    wes[1] = 1'b1; f3s[1] = 3'b001; addrs[1] = 32'h0000_0301;
    for (int k = 0; k < 2; k++) begin
      tick();
      issue(wes[k], f3s[k], addrs[k], 32'hFFFF_FFFF);
      tests_run++; if (mif.o_misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis%0d_flag got %h exp 1", k, mif.o_misaligned); end
      tests_run++; if (mif.o_stall !== 1'b0) begin tests_failed++; $display("FAIL mis%0d_stall got %h exp 0", k, mif.o_stall); end
      tick();
      tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL mis%0d_bus_en got %h exp 0", k, mif.o_bus_en); end
      mif.i_en = 1'b0; #1;
      tests_run++; if (mif.o_misaligned !== 1'b0) begin tests_failed++; $display("FAIL mis%0d_flag_idle got %h exp 0", k, mif.o_misaligned); end
    end
  endtask

  task automatic test_reset_mid_bus();
    tick();
    issue(1'b0, 3'b010, 32'h0000_0600, 32'h0);
    tick();
    tests_run++; if (mif.o_bus_en !== 1'b1) begin tests_failed++; $display("FAIL rstmid_bus_en_before got %h exp 1", mif.o_bus_en); end
    i_rst = 1'b0;
    tick();
    tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bus_en got %h exp 0", mif.o_bus_en); end
    tests_run++; if (mif.o_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstmid_rdata got %h exp 0", mif.o_rdata); end
    i_rst = 1'b1; mif.i_en = 1'b0;
    tick();
    mif.i_bus_rdata = 32'hFFFFFFFF; mif.i_bus_ack = 1'b1;
    tick(); tick();
    tests_run++; if (mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL late_ack_bus_en got %h exp 0", mif.o_bus_en); end
    tests_run++; if (mif.o_rdata !== 32'h0) begin tests_failed++; $display("FAIL late_ack_rdata got %h exp 0", mif.o_rdata); end
    mif.i_bus_ack = 1'b0;
    // A fresh access still starts from IDLE afterwards
    issue(1'b0, 3'b010, 32'h0000_0700, 32'h0);
    tests_run++; if (mif.o_stall !== 1'b1 || mif.o_bus_en !== 1'b0) begin tests_failed++; $display("FAIL post_rst_idle got stall=%h en=%h exp stall=1 en=0", mif.o_stall, mif.o_bus_en); end
    mif.i_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_back_to_back();
    test_lh();
    test_stores();
    test_wait_states();
    test_misaligned();
    test_reset_mid_bus();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
